// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: FETCH/HOLD/HALT control, a one-entry skid
// buffer for words acked under stall, redirect override and halt detection.
module instruction_fetch (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [19:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [7:0]  redirect_pc,
    output logic [19:0] instruction,
    output logic [7:0]  pc_out,
    output logic        instr_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [19:0] instr_q, instr_d;
    logic [7:0]  pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic [19:0] skid_word_q, skid_word_d;
    logic [7:0]  skid_pc_q, skid_pc_d;

    logic        deliver;
    logic        capture;
    logic [19:0] dlv_word;
    logic [7:0]  dlv_pc;
    logic        dlv_halt;

    // Source of the word handed to decode: live memory data or the skid entry.
    always_comb begin
        deliver  = 1'b0;
        capture  = 1'b0;
        dlv_word = skid_word_q;
        dlv_pc   = skid_pc_q;
        unique case (state_q)
            FETCH: begin
                dlv_word = imem_data;
                dlv_pc   = pc_q;
                deliver  = imem_ack && !stall;
                capture  = imem_ack && stall;
            end
            HOLD: begin
                deliver = !stall;
            end
            default: begin
                deliver = 1'b0;
            end
        endcase
    end

    assign dlv_halt = (dlv_word[19:16] == OP_HALT);

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = FETCH;
        end else if (deliver) begin
            state_d = dlv_halt ? HALT : FETCH;
        end else if (capture) begin
            state_d = HOLD;
        end
    end

    // Output logic
    always_comb begin
        imem_req = (state_q == FETCH) && reset;
        halted   = (state_q == HALT);
    end

    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;

    // Datapath next-state; redirect wins over ack, stall and state.
    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_out_d    = pc_out_q;
        valid_d     = valid_q;
        skid_word_d = skid_word_q;
        skid_pc_d   = skid_pc_q;
        if (redirect) begin
            pc_d        = redirect_pc;
            valid_d     = 1'b0;
            skid_word_d = '0;
            skid_pc_d   = '0;
        end else if (deliver) begin
            instr_d  = dlv_word;
            pc_out_d = dlv_pc;
            valid_d  = 1'b1;
            pc_d     = dlv_pc + 8'd1;
        end else if (capture) begin
            skid_word_d = imem_data;
            skid_pc_d   = pc_q;
        end else if (!stall) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q        <= '0;
            instr_q     <= '0;
            pc_out_q    <= '0;
            valid_q     <= 1'b0;
            skid_word_q <= '0;
            skid_pc_q   <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc_out_q    <= pc_out_d;
            valid_q     <= valid_d;
            skid_word_q <= skid_word_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then random traffic,
// all checked against a queue-based behavioural model.
module tb_instruction_fetch;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [19:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic [19:0] instruction;
    logic [7:0]  pc_out;
    logic        instr_valid;
    logic        halted;

    instruction_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instruction (instruction),
        .pc_out      (pc_out),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [19:0] w;
        logic [7:0]  p;
    } skid_t;

    int n_vec = 0;
    int n_bad = 0;

    logic [19:0] mem [256];

    logic [7:0]  m_pc;
    logic [7:0]  m_pcout;
    logic [19:0] m_instr;
    bit          m_valid;
    bit          m_halt;
    bit          m_known;
    skid_t       skid_q[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic deliver(input logic [19:0] w, input logic [7:0] p);
        m_instr = w;
        m_pcout = p;
        m_valid = 1'b1;
        m_pc    = 8'((p + 1) % 256);
        if (w[19:16] == 4'hF) m_halt = 1'b1;
    endtask

    // Reference behaviour, applied at each rising edge with the held inputs.
    task automatic model_step();
        skid_t s;
        if (!reset) begin
            m_pc    = 0;
            m_pcout = 0;
            m_instr = 0;
            m_valid = 0;
            m_halt  = 0;
            skid_q.delete();
            m_known = 1;
        end else if (redirect) begin
            m_pc    = redirect_pc;
            m_valid = 0;
            m_halt  = 0;
            skid_q.delete();
        end else if (m_halt) begin
            if (!stall) m_valid = 0;
        end else if (skid_q.size() != 0) begin
            if (!stall) begin
                s = skid_q.pop_front();
                deliver(s.w, s.p);
            end
        end else if (imem_ack && !stall) begin
            deliver(imem_data, m_pc);
        end else if (imem_ack && stall) begin
            s.w = imem_data;
            s.p = m_pc;
            skid_q.push_back(s);
        end else if (!stall) begin
            m_valid = 0;
        end
    endtask

    task automatic check_outputs();
        if (!m_known) return;
        chk("imem_req", imem_req, !m_halt && skid_q.size() == 0 && reset);
        chk("imem_addr", imem_addr, m_pc);
        chk("instruction", instruction, m_instr);
        chk("pc_out", pc_out, m_pcout);
        chk("instr_valid", instr_valid, m_valid);
        chk("halted", halted, m_halt);
    endtask

    task automatic cycle(input bit rst, input bit ack, input bit stl,
                         input bit rdr, input logic [7:0] rpc);
        @(negedge clock);
        reset       = rst;
        imem_ack    = ack;
        stall       = stl;
        redirect    = rdr;
        redirect_pc = rpc;
        imem_data   = ack ? mem[m_pc] : 20'($urandom);
        #1 check_outputs();
        @(posedge clock);
        model_step();
        #1;
    endtask

    initial begin
        m_known     = 0;
        m_pc        = 0;
        m_halt      = 0;
        m_valid     = 0;
        reset       = 0;
        imem_ack    = 0;
        imem_data   = 0;
        stall       = 0;
        redirect    = 0;
        redirect_pc = 0;
        for (int i = 0; i < 256; i++) mem[i] = 20'($urandom);
        mem[0]     = 20'hC0F00;
        mem[1]     = 20'hE0F00;
        mem[2]     = 20'h10000;
        mem[5]     = 20'h21230;
        mem[9]     = 20'hF0000;
        mem[8'h40] = 20'h0ABCD;
        mem[8'hFF] = 20'h12345;

        // Reset state
        cycle(0, 1, 0, 1, 8'h33);
        cycle(0, 1, 0, 0, 8'h00);
        chk("rst_instr", instruction, 20'h00000);
        chk("rst_pcout", pc_out, 8'h00);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_req", imem_req, 1'b0);

        // Straight-line fetch
        cycle(1, 1, 0, 0, 8'h00);
        chk("sl0_instr", instruction, 20'hC0F00);
        chk("sl0_pc", pc_out, 8'h00);
        cycle(1, 1, 0, 0, 8'h00);
        chk("sl1_instr", instruction, 20'hE0F00);
        chk("sl1_pc", pc_out, 8'h01);
        cycle(1, 1, 0, 0, 8'h00);
        chk("sl2_instr", instruction, 20'h10000);
        chk("sl2_pc", pc_out, 8'h02);
        chk("sl2_valid", instr_valid, 1'b1);

        // Stall skid at pc=5
        cycle(1, 0, 0, 1, 8'h05);
        cycle(1, 1, 1, 0, 8'h00);
        chk("sk_req", imem_req, 1'b0);
        chk("sk_instr", instruction, 20'h10000);
        cycle(1, 1, 1, 0, 8'h00);
        cycle(1, 1, 1, 0, 8'h00);
        chk("sk_hold_req", imem_req, 1'b0);
        chk("sk_hold_valid", instr_valid, 1'b0);
        cycle(1, 0, 0, 0, 8'h00);
        chk("sk_instr_rel", instruction, 20'h21230);
        chk("sk_pc_rel", pc_out, 8'h05);
        chk("sk_next_addr", imem_addr, 8'h06);

        // Redirect while holding drops the skid word
        cycle(1, 0, 0, 1, 8'h30);
        cycle(1, 1, 1, 0, 8'h00);
        cycle(1, 0, 1, 1, 8'h40);
        chk("rd_valid", instr_valid, 1'b0);
        chk("rd_addr", imem_addr, 8'h40);
        chk("rd_req", imem_req, 1'b1);
        cycle(1, 1, 0, 0, 8'h00);
        chk("rd_pcout", pc_out, 8'h40);
        chk("rd_instr", instruction, 20'h0ABCD);

        // Halt at pc=9
        cycle(1, 0, 0, 1, 8'h09);
        cycle(1, 1, 0, 0, 8'h00);
        chk("h_halted", halted, 1'b1);
        chk("h_req", imem_req, 1'b0);
        chk("h_valid", instr_valid, 1'b1);
        chk("h_addr", imem_addr, 8'h0A);
        cycle(1, 1, 1, 0, 8'h00);
        chk("h_stall_valid", instr_valid, 1'b1);
        cycle(1, 1, 0, 0, 8'h00);
        chk("h_drop_valid", instr_valid, 1'b0);
        chk("h_addr2", imem_addr, 8'h0A);
        cycle(1, 0, 0, 1, 8'h00);
        chk("h_resume_halted", halted, 1'b0);
        chk("h_resume_addr", imem_addr, 8'h00);
        cycle(1, 1, 0, 0, 8'h00);
        chk("h_resume_instr", instruction, 20'hC0F00);

        // Wrap at 8'hFF
        cycle(1, 0, 0, 1, 8'hFF);
        cycle(1, 1, 0, 0, 8'h00);
        chk("wr_addr", imem_addr, 8'h00);
        chk("wr_pcout", pc_out, 8'hFF);

        // Reset during a pending stall, with redirect also asserted
        cycle(1, 1, 1, 0, 8'h00);
        cycle(1, 1, 1, 0, 8'h00);
        cycle(0, 1, 1, 1, 8'h77);
        chk("mr_instr", instruction, 20'h00000);
        chk("mr_pcout", pc_out, 8'h00);
        chk("mr_valid", instr_valid, 1'b0);
        chk("mr_addr", imem_addr, 8'h00);
        chk("mr_req", imem_req, 1'b0);
        cycle(1, 1, 0, 0, 8'h00);
        chk("mr_first_pc", pc_out, 8'h00);

        // Random traffic
        repeat (3000) begin
            cycle($urandom_range(0, 99) != 0,
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 3,
                  $urandom_range(0, 99) < 5,
                  8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
